// File: rtl/xadac_pkg.sv
// Shared xadac types and widths used by the load unit and its OBI neighbours.
package xadac_pkg;

    localparam int unsigned XadacAddrWidth   = 32;
    localparam int unsigned XadacVectorWidth = 128;
    localparam int unsigned XadacIdWidth     = 2;

    typedef logic [XadacAddrWidth-1:0]   AddrT;
    typedef logic [XadacIdWidth-1:0]     IdT;
    typedef logic [XadacVectorWidth-1:0] VectorT;

    typedef struct packed {
        VectorT rdata;
        IdT     id;
    } ObiRespT;

    // Pointer width with one extra wrap bit to tell full from empty.
    function automatic int unsigned ptr_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xadac_fifo.sv
// Small power-of-two FIFO with wrap-bit pointers and a registered head.
module xadac_fifo
    import xadac_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = ptr_width(Depth);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    T              mem_q [Depth];
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
    end

    // Storage is cleared too so the head reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/xadac_obi_id_adapter.sv
// Bridges ID-tagged OBI with rready back-pressure onto an in-order, ID-less,
// non-stallable memory port; credits bound everything in flight or buffered.
module xadac_obi_id_adapter
    import xadac_pkg::*;
#(
    parameter int unsigned AddrWidth      = XadacAddrWidth,
    parameter int unsigned DataWidth      = XadacVectorWidth,
    parameter int unsigned IdWidth        = XadacIdWidth,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   slv_req,
    output logic                   slv_gnt,
    input  logic [AddrWidth-1:0]   slv_addr,
    input  logic                   slv_we,
    input  logic [DataWidth/8-1:0] slv_be,
    input  logic [DataWidth-1:0]   slv_wdata,
    input  logic [IdWidth-1:0]     slv_aid,
    output logic                   slv_rvalid,
    input  logic                   slv_rready,
    output logic [DataWidth-1:0]   slv_rdata,
    output logic [IdWidth-1:0]     slv_rid,
    output logic                   mst_req,
    input  logic                   mst_gnt,
    output logic [AddrWidth-1:0]   mst_addr,
    output logic                   mst_we,
    output logic [DataWidth/8-1:0] mst_be,
    output logic [DataWidth-1:0]   mst_wdata,
    input  logic                   mst_rvalid,
    input  logic [DataWidth-1:0]   mst_rdata,
    output logic                   err
);

    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    logic [CntW-1:0] credits_q, credits_d;
    logic            err_q, err_d;
    logic            credit_ok, issue, spurious;
    logic            id_pop, id_full, id_empty;
    logic            rsp_push, rsp_pop, rsp_full, rsp_empty;
    IdT              id_head;
    ObiRespT         rsp_in, rsp_head;

    assign mst_addr  = slv_addr;
    assign mst_we    = slv_we;
    assign mst_be    = slv_be;
    assign mst_wdata = slv_wdata;

    // Only registered credits gate the grant: a pop frees its slot next cycle.
    assign credit_ok = (credits_q < CntW'(MaxOutstanding));
    assign mst_req   = slv_req && credit_ok;
    assign slv_gnt   = mst_gnt && credit_ok;
    assign issue     = slv_req && slv_gnt;

    assign spurious = mst_rvalid && id_empty;
    assign id_pop   = mst_rvalid && !id_empty;
    assign rsp_push = id_pop;
    assign rsp_in   = '{rdata: mst_rdata, id: id_head};

    assign slv_rvalid = !rsp_empty;
    assign slv_rdata  = rsp_head.rdata;
    assign slv_rid    = rsp_head.id;
    assign rsp_pop    = slv_rvalid && slv_rready;

    xadac_fifo #(
        .Depth (MaxOutstanding),
        .T     (IdT)
    ) i_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .data_i  (slv_aid),
        .pop_i   (id_pop),
        .full_o  (id_full),
        .empty_o (id_empty),
        .head_o  (id_head)
    );

    xadac_fifo #(
        .Depth (MaxOutstanding),
        .T     (ObiRespT)
    ) i_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .data_i  (rsp_in),
        .pop_i   (rsp_pop),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .head_o  (rsp_head)
    );

    always_comb begin
        credits_d = credits_q;
        unique case ({issue, rsp_pop})
            2'b10:   credits_d = credits_q + CntW'(1);
            2'b01:   credits_d = credits_q - CntW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Overflow attempts are unreachable while credits hold, but are flagged anyway.
    assign err_d = err_q || spurious || (issue && id_full) || (rsp_push && rsp_full);
    assign err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_xadac_obi_id_adapter.sv
// Directed stimulus with a response scoreboard checked by an independent monitor.
module tb_xadac_obi_id_adapter;

    logic         clk, rst;
    logic         slv_req, slv_gnt, slv_we, slv_rvalid, slv_rready;
    logic [31:0]  slv_addr, mst_addr;
    logic [15:0]  slv_be, mst_be;
    logic [127:0] slv_wdata, slv_rdata, mst_wdata, mst_rdata;
    logic [1:0]   slv_aid, slv_rid;
    logic         mst_req, mst_gnt, mst_we, mst_rvalid, err;

    typedef struct {
        logic [1:0]   id;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    xadac_obi_id_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .slv_req    (slv_req),
        .slv_gnt    (slv_gnt),
        .slv_addr   (slv_addr),
        .slv_we     (slv_we),
        .slv_be     (slv_be),
        .slv_wdata  (slv_wdata),
        .slv_aid    (slv_aid),
        .slv_rvalid (slv_rvalid),
        .slv_rready (slv_rready),
        .slv_rdata  (slv_rdata),
        .slv_rid    (slv_rid),
        .mst_req    (mst_req),
        .mst_gnt    (mst_gnt),
        .mst_addr   (mst_addr),
        .mst_we     (mst_we),
        .mst_be     (mst_be),
        .mst_wdata  (mst_wdata),
        .mst_rvalid (mst_rvalid),
        .mst_rdata  (mst_rdata),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_rsp(input logic [1:0] id, input logic [127:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Holds the request through `stall` ungranted cycles, then one granted cycle.
    task automatic issue(input logic [1:0] aid, input logic [31:0] addr, input int stall, input logic we);
        logic [127:0] wd;
        wd        = {addr, ~addr, addr, ~addr};
        slv_req   = 1'b1;
        slv_aid   = aid;
        slv_addr  = addr;
        slv_we    = we;
        slv_wdata = wd;
        mst_gnt   = 1'b0;
        repeat (stall) begin
            #1 chk("gnt_during_stall", slv_gnt, 0);
            cyc();
        end
        mst_gnt = 1'b1;
        #1;
        chk("slv_gnt", slv_gnt, 1);
        chk("mst_req", mst_req, 1);
        chk("mst_addr", mst_addr, addr);
        chk("mst_wdata", mst_wdata, wd);
        chk("mst_we", mst_we, we);
        cyc();
        slv_req = 1'b0;
        mst_gnt = 1'b0;
        slv_we  = 1'b0;
    endtask

    task automatic mem_resp(input logic [127:0] data);
        mst_rvalid = 1'b1;
        mst_rdata  = data;
        cyc();
        mst_rvalid = 1'b0;
    endtask

    // Monitor: compares every accepted response and checks hold-stability under stall.
    initial begin : monitor
        logic         hold;
        logic [1:0]   h_id;
        logic [127:0] h_data;
        exp_t         e;
        hold = 1'b0;
        h_id = '0;
        h_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stable_rvalid", slv_rvalid, 1);
                    chk("stable_rid", slv_rid, h_id);
                    chk("stable_rdata", slv_rdata, h_data);
                end
                if (slv_rvalid && slv_rready) begin
                    if (exp_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_rsp: got rid %0h rdata %0h, expected none", slv_rid, slv_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rid", slv_rid, e.id);
                        chk("rsp_rdata", slv_rdata, e.data);
                    end
                end
                hold   = slv_rvalid && !slv_rready;
                h_id   = slv_rid;
                h_data = slv_rdata;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        slv_req    = 1'b0;
        slv_addr   = '0;
        slv_we     = 1'b0;
        slv_be     = 16'hFFFF;
        slv_wdata  = '0;
        slv_aid    = '0;
        slv_rready = 1'b0;
        mst_gnt    = 1'b0;
        mst_rvalid = 1'b0;
        mst_rdata  = '0;
        #2;
        chk("rst_slv_gnt", slv_gnt, 0);
        chk("rst_slv_rvalid", slv_rvalid, 0);
        chk("rst_slv_rdata", slv_rdata, 0);
        chk("rst_slv_rid", slv_rid, 0);
        chk("rst_mst_req", mst_req, 0);
        chk("rst_err", err, 0);
        cyc(2);
        rst = 1'b0;
        cyc();

        // Single read, response 3 cycles after grant, no bypass.
        expect_rsp(2'd2, 128'hDEAD);
        issue(2'd2, 32'h100, 0, 1'b0);
        cyc(2);
        mst_rvalid = 1'b1;
        mst_rdata  = 128'hDEAD;
        #1 chk("no_bypass", slv_rvalid, 0);
        cyc();
        mst_rvalid = 1'b0;
        #1;
        chk("t1_rvalid", slv_rvalid, 1);
        chk("t1_rid", slv_rid, 2);
        chk("t1_rdata", slv_rdata, 128'hDEAD);
        slv_rready = 1'b1;
        cyc();
        slv_rready = 1'b0;
        #1 chk("t1_drained", slv_rvalid, 0);

        // Back-pressure: four credits fill, fifth waits until the cycle after a pop.
        for (int i = 0; i < 4; i++) begin
            expect_rsp(2'(i), 128'h1000 + 128'(i));
            issue(2'(i), 32'h200 + 32'(i * 16), 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) mem_resp(128'h1000 + 128'(i));
        slv_req  = 1'b1;
        slv_aid  = 2'd0;
        slv_addr = 32'h300;
        mst_gnt  = 1'b1;
        #1;
        chk("bp_mst_req_blocked", mst_req, 0);
        chk("bp_gnt_blocked", slv_gnt, 0);
        cyc();
        slv_rready = 1'b1;
        #1 chk("bp_no_same_cycle_gnt", slv_gnt, 0);
        cyc();
        slv_rready = 1'b0;
        #1;
        chk("bp_gnt_after_pop", slv_gnt, 1);
        chk("bp_mst_req_after_pop", mst_req, 1);
        expect_rsp(2'd0, 128'h1004);
        cyc();
        slv_req = 1'b0;
        mst_gnt = 1'b0;
        mem_resp(128'h1004);
        slv_rready = 1'b1;
        cyc(5);
        slv_rready = 1'b0;
        #1 chk("bp_drained", slv_rvalid, 0);

        // Reordered/duplicate IDs with grant stalls; one write in the mix.
        slv_rready = 1'b1;
        expect_rsp(2'd3, 128'hA0);
        issue(2'd3, 32'h400, 2, 1'b0);
        expect_rsp(2'd1, 128'hA1);
        issue(2'd1, 32'h410, 0, 1'b0);
        expect_rsp(2'd1, 128'hA2);
        issue(2'd1, 32'h420, 1, 1'b1);
        expect_rsp(2'd2, 128'hA3);
        issue(2'd2, 32'h430, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mem_resp(128'hA0 + 128'(i));
            cyc();
        end
        cyc(2);
        slv_rready = 1'b0;
        #1 chk("ids_drained", slv_rvalid, 0);

        // Simultaneous issue and pop at credits=3, then memory response during pops.
        for (int i = 1; i < 4; i++) begin
            expect_rsp(2'(i), 128'hB0 + 128'(i));
            issue(2'(i), 32'h500 + 32'(i * 16), 0, 1'b0);
        end
        for (int i = 1; i < 4; i++) mem_resp(128'hB0 + 128'(i));
        slv_rready = 1'b1;
        expect_rsp(2'd0, 128'hB4);
        issue(2'd0, 32'h540, 0, 1'b0);
        slv_rready = 1'b0;
        expect_rsp(2'd2, 128'hB5);
        issue(2'd2, 32'h550, 0, 1'b0);
        slv_req = 1'b1;
        mst_gnt = 1'b1;
        #1 chk("sim_credits_full", slv_gnt, 0);
        slv_req    = 1'b0;
        mst_gnt    = 1'b0;
        slv_rready = 1'b1;
        mem_resp(128'hB4);
        mem_resp(128'hB5);
        cyc(6);
        slv_rready = 1'b0;
        #1 chk("sim_drained", slv_rvalid, 0);

        // Spurious memory response: sticky error, nothing delivered.
        chk("err_clear_before", err, 0);
        mem_resp(128'hBAD);
        #1;
        chk("err_set", err, 1);
        chk("spurious_no_rvalid", slv_rvalid, 0);
        cyc(3);
        chk("err_sticky", err, 1);
        chk("spurious_still_no_rvalid", slv_rvalid, 0);
        expect_rsp(2'd3, 128'hC3);
        issue(2'd3, 32'h600, 0, 1'b0);
        mem_resp(128'hC3);
        slv_rready = 1'b1;
        cyc();
        slv_rready = 1'b0;
        #1;
        chk("after_spurious_drained", slv_rvalid, 0);
        chk("err_still_set", err, 1);

        // Asynchronous reset with two outstanding and one buffered.
        issue(2'd1, 32'h700, 0, 1'b0);
        issue(2'd2, 32'h710, 0, 1'b0);
        issue(2'd3, 32'h720, 0, 1'b0);
        mem_resp(128'hD1);
        #1;
        chk("pre_rst_rvalid", slv_rvalid, 1);
        chk("pre_rst_rid", slv_rid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rvalid", slv_rvalid, 0);
        chk("async_rst_rdata", slv_rdata, 0);
        chk("async_rst_rid", slv_rid, 0);
        chk("async_rst_err", err, 0);
        chk("async_rst_gnt", slv_gnt, 0);
        exp_q.delete();
        cyc(2);
        rst = 1'b0;
        cyc();
        expect_rsp(2'd1, 128'h5A5A);
        issue(2'd1, 32'h800, 0, 1'b0);
        cyc();
        mem_resp(128'h5A5A);
        slv_rready = 1'b1;
        cyc();
        slv_rready = 1'b0;
        #1;
        chk("post_rst_drained", slv_rvalid, 0);
        chk("post_rst_err", err, 0);
        cyc(2);
        chk("scoreboard_empty", 128'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/xadac_obi_id_adapter.md
Name: xadac_obi_id_adapter

Overview:
Downstream neighbour of the xadac vector load unit. Accepts ID-tagged OBI requests (aid/rid, rready back-pressure) and drives a plain in-order OBI memory port that has no IDs and no response back-pressure. Records each issued aid in order and re-tags memory responses with it. Buffers responses so the memory side can never overflow while the requester stalls rready.

Parameters:
AddrWidth, 32, request address width
DataWidth, 128, data width (equals xadac VectorWidth)
IdWidth, 2, transaction ID width (equals xadac IdWidth)
MaxOutstanding, 4, max transactions issued but not yet accepted by the requester; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
slv_req  in  1  requester OBI A valid
slv_gnt  out  1  requester OBI A grant
slv_addr  in  AddrWidth  address
slv_we  in  1  write enable
slv_be  in  DataWidth/8  byte enables
slv_wdata  in  DataWidth  write data
slv_aid  in  IdWidth  request ID
slv_rvalid  out  1  response valid
slv_rready  in  1  response ready
slv_rdata  out  DataWidth  response data
slv_rid  out  IdWidth  response ID
mst_req  out  1  memory OBI A valid
mst_gnt  in  1  memory OBI A grant
mst_addr  out  AddrWidth  address
mst_we  out  1  write enable
mst_be  out  DataWidth/8  byte enables
mst_wdata  out  DataWidth  write data
mst_rvalid  in  1  memory response valid; no ready, must be sunk
mst_rdata  in  DataWidth  memory response data
err  out  1  sticky protocol-error flag

Behaviour:
- Interface decided: single clock clk; reset rst asynchronous, active-high.
- Reset values: slv_gnt=0, slv_rvalid=0, slv_rdata=0, slv_rid=0, mst_req=0, err=0. Credit counter, ID FIFO and response FIFO are empty.
- A channel is combinational pass-through: mst_addr/we/be/wdata equal the slv_* fields.
- credit_ok = (credits_q < MaxOutstanding), evaluated on registered state only. A pop in the same cycle does not free a credit until the next cycle; no rready->gnt path.
- mst_req = slv_req && credit_ok.
- slv_gnt = mst_gnt && credit_ok.
- Issue: on slv_req && slv_gnt, slv_aid is pushed to the ID FIFO.
- Memory response: on mst_rvalid, pop the ID FIFO head and push {mst_rdata, id} into the response FIFO.
- Writes return responses exactly like reads; rdata is passed through as returned.
- Response channel:
  - slv_rvalid = response FIFO not empty; slv_rdata/slv_rid are driven from the head.
  - Pop on slv_rvalid && slv_rready.
  - Latency: mst_rvalid in cycle t gives slv_rvalid in cycle t+1 at the earliest; no bypass.
  - slv_rvalid/rdata/rid stay stable while rready=0.
- credits_q: +1 on issue, -1 on response pop. Simultaneous issue and pop leaves it unchanged. Range 0..MaxOutstanding.
- Ordering: responses reach the requester in issue order. The rid sequence equals the issued aid sequence, including duplicate IDs.
- Credits cover the full response path, so neither FIFO can overflow; occupancy of both FIFOs together is at most MaxOutstanding.
- FIFO pointers are log2(MaxOutstanding)+1 bits with natural wrap. Full = MSBs differ and LSBs equal.
- Spurious mst_rvalid (ID FIFO empty): set err (sticky until rst); push nothing; counters unchanged.
- Reset mid-operation clears all state and drops in-flight responses. The memory must be reset in the same domain.

Decomposition:
- xadac_pkg supplies AddrT, IdT, VectorT and the width constants.
- Add to the package: ObiRespT struct {VectorT rdata; IdT id}.
- Sub-module xadac_fifo (parameters Depth, type T; ports push/pop/full/empty/head; async active-high reset) is instantiated twice: ID FIFO (T=IdT) and response FIFO (T=ObiRespT).

Test Plan:
- Single read: aid=2, addr=0x100, mst_gnt=1, mst_rvalid 3 cycles later with rdata=0xDEAD -> next cycle slv_rvalid=1, rid=2, rdata=0xDEAD; popped with rready=1; credits return to 0.
- Back-pressure: rready=0; issue aid 0,1,2,3; memory answers all -> 4 grants accepted. 5th slv_req sees mst_req=0, slv_gnt=0. One pop -> 5th granted the following cycle, not the same cycle.
- Reordered IDs: issue aid 3,1,1,2 with variable mst_gnt stalls -> rid sequence 3,1,1,2 with matching data.
- Simultaneous: credits=3, issue and pop in the same cycle -> credits stay 3; mst_rvalid concurrent with a pop -> no data loss.
- Spurious mst_rvalid with nothing outstanding -> err=1 and stays 1; slv_rvalid stays 0.
- Reset with 2 outstanding and 1 buffered -> all outputs return to 0 asynchronously; after release, a new aid=1 transaction completes normally.
